// File: rtl/pio_regfile_arbiter.sv
// Round-robin arbiter sharing one pioRegfileRead/pioRegfileWrite slave between NREQ requesters.
// Optional slave-ack watchdog enabled by defining PIO_ARB_TIMEOUT_EN.
module pio_regfile_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           up_req,
  input  logic [NREQ-1:0]           up_wr,
  input  logic [NREQ*AW-1:0]        up_addr,
  input  logic [NREQ*DW-1:0]        up_wdata,
  output logic [NREQ-1:0]           up_ack,
  output logic [DW-1:0]             up_rdata,
  output logic                      pioRegfileRead_req,
  output logic [AW-1:0]             pioRegfileRead_addr,
  input  logic                      pioRegfileRead_ack,
  input  logic [DW-1:0]             pioRegfileRead_return,
  output logic                      pioRegfileWrite_req,
  output logic [AW-1:0]             pioRegfileWrite_addr,
  output logic [DW-1:0]             pioRegfileWrite_data,
  input  logic                      pioRegfileWrite_ack,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_idx,
  output logic                      err
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES == 0) begin : gBadParam
    $error("pio_regfile_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e         stateQ, stateD;
  logic [IW-1:0]  rrPtrQ, rrPtrD, grantQ, grantD;
  logic           wrQ, wrD;
  logic [AW-1:0]  addrQ, addrD;
  logic [DW-1:0]  wdataQ, wdataD, rdataQ, rdataD;
  logic           rdReqQ, rdReqD, wrReqQ, wrReqD;
  logic [NREQ-1:0] ackQ, ackD;
  logic           busyQ, busyD;
  logic           found;
  logic [IW-1:0]  pick, cand;
  logic           slaveAck;

  logic [AW-1:0]  addrArr  [NREQ];
  logic [DW-1:0]  wdataArr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : gUnpack
    assign addrArr[g]  = up_addr[g*AW +: AW];
    assign wdataArr[g] = up_wdata[g*DW +: DW];
  end

`ifdef PIO_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cntQ, cntD;
  logic          errQ, errD;
`endif

  // First requester at or above the RR pointer, wrapping at NREQ-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rrPtrQ) + k) % NREQ);
      if (!found && up_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign slaveAck = wrQ ? pioRegfileWrite_ack : pioRegfileRead_ack;

  always_comb begin
    stateD = stateQ;
    rrPtrD = rrPtrQ;
    grantD = grantQ;
    wrD    = wrQ;
    addrD  = addrQ;
    wdataD = wdataQ;
    rdataD = rdataQ;
    rdReqD = rdReqQ;
    wrReqD = wrReqQ;
    ackD   = '0;
    busyD  = busyQ;
`ifdef PIO_ARB_TIMEOUT_EN
    cntD   = cntQ;
    errD   = errQ;
`endif
    unique case (stateQ)
      StIdle: begin
        if (found) begin
          grantD = pick;
          wrD    = up_wr[pick];
          addrD  = addrArr[pick];
          wdataD = wdataArr[pick];
          wrReqD = up_wr[pick];
          rdReqD = ~up_wr[pick];
          busyD  = 1'b1;
          stateD = StBusy;
`ifdef PIO_ARB_TIMEOUT_EN
          cntD   = '0;
`endif
        end
      end
      StBusy: begin
        if (slaveAck) begin
          rdReqD = 1'b0;
          wrReqD = 1'b0;
          if (!wrQ) rdataD = pioRegfileRead_return;
          ackD[grantQ] = 1'b1;
          rrPtrD = (grantQ == IW'(NREQ - 1)) ? '0 : grantQ + 1'b1;
          stateD = StAck;
        end
`ifdef PIO_ARB_TIMEOUT_EN
        else if (cntQ == CW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the hung slave; the winner still gets its ack.
          rdReqD = 1'b0;
          wrReqD = 1'b0;
          rdataD = DW'(32'hDEADDEAD);
          ackD[grantQ] = 1'b1;
          rrPtrD = (grantQ == IW'(NREQ - 1)) ? '0 : grantQ + 1'b1;
          errD   = 1'b1;
          stateD = StAck;
        end else begin
          cntD = cntQ + 1'b1;
        end
`endif
      end
      StAck: begin
        busyD  = 1'b0;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
      rrPtrQ <= '0;
      grantQ <= '0;
      wrQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      rdataQ <= '0;
      rdReqQ <= 1'b0;
      wrReqQ <= 1'b0;
      ackQ   <= '0;
      busyQ  <= 1'b0;
`ifdef PIO_ARB_TIMEOUT_EN
      cntQ   <= '0;
      errQ   <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      rrPtrQ <= rrPtrD;
      grantQ <= grantD;
      wrQ    <= wrD;
      addrQ  <= addrD;
      wdataQ <= wdataD;
      rdataQ <= rdataD;
      rdReqQ <= rdReqD;
      wrReqQ <= wrReqD;
      ackQ   <= ackD;
      busyQ  <= busyD;
`ifdef PIO_ARB_TIMEOUT_EN
      cntQ   <= cntD;
      errQ   <= errD;
`endif
    end
  end

  assign up_ack               = ackQ;
  assign up_rdata             = rdataQ;
  assign pioRegfileRead_req   = rdReqQ;
  assign pioRegfileRead_addr  = addrQ;
  assign pioRegfileWrite_req  = wrReqQ;
  assign pioRegfileWrite_addr = addrQ;
  assign pioRegfileWrite_data = wdataQ;
  assign busy                 = busyQ;
  assign grant_idx            = grantQ;
`ifdef PIO_ARB_TIMEOUT_EN
  assign err = errQ;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/pio_regfile_arbiter.md
Name: pio_regfile_arbiter

Overview:
- Round-robin arbiter sharing one HSIMPLE programmed-I/O register-file slave (pioRegfileRead/pioRegfileWrite port pair) between NREQ host-side requesters.
- Each requester presents one unified req/ack channel carrying a read or a write.
- The arbiter serialises transactions, drives the slave's separate read and write channels, and routes the ack and read data back to the winner.
- Sits between host/debug masters and a Kiwi-generated slave such as TEST42SLAVE.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 32, address width
DW, 32, data width
TIMEOUT_CYCLES, 1024, slave-ack watchdog limit (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
up_req  in  NREQ  per-requester request, held high until ack
up_wr  in  NREQ  1=write, 0=read; stable while up_req high
up_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
up_wdata  in  NREQ*DW  packed write data
up_ack  out  NREQ  one-cycle completion pulse to the winner
up_rdata  out  DW  read return, valid while up_ack is nonzero
pioRegfileRead_req  out  1  slave read request
pioRegfileRead_addr  out  AW  slave read address
pioRegfileRead_ack  in  1  slave read ack
pioRegfileRead_return  in  DW  slave read data
pioRegfileWrite_req  out  1  slave write request
pioRegfileWrite_addr  out  AW  slave write address
pioRegfileWrite_data  out  DW  slave write data
pioRegfileWrite_ack  in  1  slave write ack
busy  out  1  transaction in flight
grant_idx  out  clog2(NREQ)  index of current or last winner
err  out  1  sticky watchdog error

Behaviour:
- Reset (reset==0, async): state IDLE. All outputs 0: up_ack, up_rdata, both slave req lines, slave addr/data, busy, grant_idx, err. RR pointer set to 0.
- FSM states are IDLE, BUSY and ACK.
- IDLE:
  - If no up_req bit is set, stay in IDLE.
  - Otherwise pick the first set bit searching upward from the RR pointer, wrapping at NREQ-1 to 0.
  - Latch the winner's index, op, address and data. Set busy=1 and grant_idx=winner. Go to BUSY.
  - Asserting in BUSY: pioRegfileWrite_req if op=write, else pioRegfileRead_req. Address and data are driven from the latched values.
  - Slave req rises on the clock edge after up_req is sampled high.
- BUSY:
  - Hold the slave req and the latched addr/data stable.
  - When the matching slave ack is sampled high: drop the slave req; capture pioRegfileRead_return into up_rdata (reads only, writes leave up_rdata unchanged); set up_ack[winner]=1; set RR pointer = winner+1 mod NREQ. Go to ACK.
  - The non-matching ack is ignored.
- ACK:
  - up_ack is high for exactly this cycle. The requester drops up_req on the same edge.
  - Next edge: clear up_ack, set busy=0, go to IDLE.
  - A requester's own just-completed req is therefore never re-granted spuriously.
- Latency:
  - Upstream req sampled to slave req: 1 cycle.
  - Slave ack sampled to up_ack: 1 cycle.
  - Minimum IDLE-to-IDLE: 3 cycles plus slave latency.
- Only one slave req is ever high; read and write are never concurrent.
- Requester deasserts up_req before it is granted: no transaction, no ack.
- Requester deasserts up_req during BUSY (protocol violation): the transaction completes and the ack is still pulsed.
- Simultaneous requests: strictly one grant per transaction. Round-robin guarantees each active requester is served within NREQ transactions.
- up_wr/addr/wdata changing after the grant: ignored; the latched values are used.
- Async reset mid-BUSY: slave req drops immediately, no ack is issued, RR pointer returns to 0.

Optional Feature:
PIO_ARB_TIMEOUT_EN
- With the macro:
  - A counter is cleared on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without a slave ack: drop the slave req, set up_rdata=32'hDEADDEAD, pulse up_ack[winner], set err=1 (sticky until reset), go to ACK.
  - A late slave ack arriving in IDLE is ignored.
- Without the macro: no counter; BUSY waits indefinitely; err is tied to 0.

Test Plan:
- Requester 0 writes 32'hdeadbeef to addr 8; slave acks 2 cycles later -> pioRegfileWrite_req high 1 cycle after up_req, addr=8, data=deadbeef; up_ack[0] one cycle; pioRegfileRead_req never high.
- Requester 1 reads addr 8 after that write; slave returns deadbeef -> up_ack[1] pulse with up_rdata=32'hdeadbeef, grant_idx=1.
- All 4 requesters assert reads in the same cycle, repeatedly -> grant order 0,1,2,3,0,1; no two slave reqs overlap; exactly one up_ack bit per transaction.
- Requester 2 writes 32'h12345678 to addr 16 while requester 3 reads addr 16 -> write granted first (pointer order), then read returns 12345678.
- reset driven 0 while BUSY -> slave req and busy go 0 without a clock edge; after release, a new request is granted with the pointer at 0.
- With PIO_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> up_ack pulses 16 cycles into BUSY with up_rdata=32'hDEADDEAD; err=1 and stays 1 until reset.
